// File: rtl/mult_initiator.sv
// Transaction-level initiator for an add-shift multiplier: takes operand requests,
// issues one start pulse per request, waits for done, and returns a golden-checked product.
module mult_initiator #(
    parameter int width_p   = 8,
    parameter int timeout_p = 64,
    parameter int cnt_w_p   = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [width_p-1:0]     req_multiplicand_i,
    input  logic [width_p-1:0]     req_multiplier_i,
    output logic                   mult_start_o,
    output logic [width_p-1:0]     mult_multiplicand_o,
    output logic [width_p-1:0]     mult_multiplier_o,
    input  logic                   mult_ready_i,
    input  logic [2*width_p-1:0]   mult_product_i,
    input  logic                   mult_done_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [2*width_p-1:0]   rsp_product_o,
    output logic                   rsp_mismatch_o,
    output logic                   rsp_timeout_o,
    output logic [1:0]             err_o,
    output logic [cnt_w_p-1:0]     txn_count_o,
    output logic [cnt_w_p-1:0]     mismatch_count_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // once raised, valid and its payload stay stable until that transfer.

    localparam int pw = 2 * width_p;
    localparam int tw = $clog2(timeout_p + 1);
    localparam logic [tw-1:0] timer_max = tw'(timeout_p - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, START, WAIT, RESP} state_e;
    typedef enum logic [1:0] {
        ERR_NONE, ERR_ILLEGAL_TRANSACTION, ERR_TIME_DESYNC, ERR_ILLEGAL_STATE
    } errnos_e;

    state_e             state;
    logic [tw-1:0]      timer;
    logic [width_p-1:0] a_q;
    logic [width_p-1:0] b_q;
    logic [pw-1:0]      golden;
    errnos_e            err_event;

    assign mult_multiplicand_o = a_q;
    assign mult_multiplier_o   = b_q;
    assign golden              = pw'(a_q) * pw'(b_q);

    // The first WAIT cycle (timer == 0) may still see the multiplier's ready from before start.
    always_comb begin
        err_event = ERR_NONE;
        if (mult_done_i && state != WAIT)
            err_event = ERR_ILLEGAL_TRANSACTION;
        else if (state == WAIT && mult_ready_i && timer != '0)
            err_event = ERR_ILLEGAL_STATE;
        else if (state == WAIT && !mult_done_i && timer == timer_max)
            err_event = ERR_TIME_DESYNC;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state            <= IDLE;
            timer            <= '0;
            a_q              <= '0;
            b_q              <= '0;
            req_ready_o      <= 1'b1;
            mult_start_o     <= 1'b0;
            rsp_valid_o      <= 1'b0;
            rsp_product_o    <= '0;
            rsp_mismatch_o   <= 1'b0;
            rsp_timeout_o    <= 1'b0;
            err_o            <= ERR_NONE;
            txn_count_o      <= '0;
            mismatch_count_o <= '0;
        end else begin
            if (err_o == ERR_NONE)
                err_o <= err_event;
            mult_start_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        a_q         <= req_multiplicand_i;
                        b_q         <= req_multiplier_i;
                        req_ready_o <= 1'b0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mult_ready_i) begin
                        mult_start_o <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // done takes priority over a timeout landing in the same cycle
                    if (mult_done_i) begin
                        rsp_product_o  <= mult_product_i;
                        rsp_mismatch_o <= (mult_product_i != golden);
                        rsp_timeout_o  <= 1'b0;
                        rsp_valid_o    <= 1'b1;
                        state          <= RESP;
                    end else if (timer == timer_max) begin
                        rsp_product_o  <= '0;
                        rsp_mismatch_o <= 1'b0;
                        rsp_timeout_o  <= 1'b1;
                        rsp_valid_o    <= 1'b1;
                        state          <= RESP;
                    end else begin
                        timer <= timer + tw'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        if (txn_count_o != '1)
                            txn_count_o <= txn_count_o + cnt_w_p'(1);
                        if (rsp_mismatch_o && mismatch_count_o != '1)
                            mismatch_count_o <= mismatch_count_o + cnt_w_p'(1);
                        state <= IDLE;
                    end
                end
                default: begin
                    req_ready_o <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
